data_sram_slave: RTL and testbench

Responder for the CPU data-SRAM port: it receives `data_sram_en/wen/addr/wdata` from the core and returns `data_sram_rdata` with one-cycle read latency. It decodes each access into a byte-writable word RAM or a small MMIO register bank (LED, switches, scratch, free-running timer). It sits beside the core in the SoC top and is the memory/peripheral end of the data bus for simulation and FPGA bring-up.

---
 rtl/data_bus_pkg.sv | 31 +++
 rtl/byte_ram.sv | 31 +++
 rtl/data_sram_slave.sv | 105 ++++++++++
 tb/tb_data_sram_slave.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared constants and helpers for the CPU data-SRAM responder.
package data_bus_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned OFF_W  = 16;

    localparam logic [DATA_W-1:0] DEFAULT_MMIO_BASE = 32'hBFAF_0000;

    localparam logic [OFF_W-1:0] OFF_LED     = 16'hF000;
    localparam logic [OFF_W-1:0] OFF_SCRATCH = 16'hF010;
    localparam logic [OFF_W-1:0] OFF_SWITCH  = 16'hF020;
    localparam logic [OFF_W-1:0] OFF_TIMER   = 16'hF0E0;

    // Replace each byte of old_word whose enable bit is set with the matching byte of new_word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [LANES-1:0]  wen
    );
        logic [DATA_W-1:0] result;
        result = old_word;
        for (int i = 0; i < int'(LANES); i++) begin
            if (wen[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module byte_ram
    import data_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and read are mutually exclusive at the port, so no read-during-write ordering is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/data_sram_slave.sv
// Data-bus responder: decodes core accesses to a byte-writable RAM or a small MMIO bank.
module data_sram_slave
    import data_bus_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 10,
    parameter logic [DATA_W-1:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic [LANES-1:0]  wen,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [7:0]        switch,
    output logic [15:0]       led
);

    localparam int unsigned LED_W = 16;
    localparam int unsigned SW_W  = 8;

    logic                is_mmio_c;
    logic                rd_c;
    logic                mmio_wr_c;
    logic [OFF_W-1:0]    offset_c;
    logic [LANES-1:0]    ram_we_c;
    logic                ram_re_c;
    logic [DATA_W-1:0]   mmio_mux_c;
    logic [DATA_W-1:0]   led_merged_c;

    logic [DATA_W-1:0]   ram_q;
    logic [DATA_W-1:0]   scratch;
    logic [DATA_W-1:0]   timer;
    logic [SW_W-1:0]     sw_meta;
    logic [SW_W-1:0]     sw_sync;
    logic [DATA_W-1:0]   mmio_rdata;
    logic                last_mmio;

    assign is_mmio_c = (addr[31:16] == MMIO_BASE[31:16]);
    assign offset_c  = addr[OFF_W-1:0];
    assign rd_c      = en && (wen == LANES'(0));
    assign mmio_wr_c = en && resetn && is_mmio_c && (wen != LANES'(0));
    assign ram_we_c  = (en && resetn && !is_mmio_c) ? wen : LANES'(0);
    assign ram_re_c  = rd_c && resetn && !is_mmio_c;

    assign led_merged_c = merge_bytes({LED_W'(0), led}, wdata, wen);

    byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .re    (ram_re_c),
        .addr  (addr[ADDR_W+1:2]),
        .wdata (wdata),
        .q     (ram_q)
    );

    // MMIO read selection; timer value is the one present before this edge's increment.
    always_comb begin
        mmio_mux_c = '0;
        unique case (offset_c)
            OFF_LED:     mmio_mux_c = {LED_W'(0), led};
            OFF_SCRATCH: mmio_mux_c = scratch;
            OFF_SWITCH:  mmio_mux_c = {(DATA_W - SW_W)'(0), sw_sync};
            OFF_TIMER:   mmio_mux_c = timer;
            default:     mmio_mux_c = '0;
        endcase
    end

    // Register bank, timer, switch synchroniser and read-path state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led        <= '0;
            scratch    <= '0;
            timer      <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
            mmio_rdata <= '0;
            last_mmio  <= 1'b1;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
            timer   <= timer + DATA_W'(1);
            if (mmio_wr_c) begin
                unique case (offset_c)
                    OFF_LED:     led     <= led_merged_c[LED_W-1:0];
                    OFF_SCRATCH: scratch <= merge_bytes(scratch, wdata, wen);
                    OFF_TIMER:   timer   <= merge_bytes(timer, wdata, wen);
                    default:     ;
                endcase
            end
            if (rd_c) begin
                last_mmio <= is_mmio_c;
                if (is_mmio_c) begin
                    mmio_rdata <= mmio_mux_c;
                end
            end
        end
    end

    // Reset parks the select on the MMIO register, which is cleared, so rdata reads 0.
    assign rdata = last_mmio ? mmio_rdata : ram_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed self-checking bench for data_sram_slave.
module tb_data_sram_slave;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch;
    logic [15:0] led;

    int vectors;
    int miscompares;

    localparam logic [31:0] A_LED     = 32'hBFAF_F000;
    localparam logic [31:0] A_SCRATCH = 32'hBFAF_F010;
    localparam logic [31:0] A_SWITCH  = 32'hBFAF_F020;
    localparam logic [31:0] A_TIMER   = 32'hBFAF_F0E0;
    localparam logic [31:0] A_UNMAP   = 32'hBFAF_F100;

    data_sram_slave #(
        .ADDR_W    (10),
        .MMIO_BASE (32'hBFAF_0000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .wen    (wen),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .switch (switch),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        en = 1'b1; wen = w; addr = a; wdata = d;
        tick();
        en = 1'b0; wen = 4'h0;
    endtask

    task automatic do_read(input logic [31:0] a);
        en = 1'b1; wen = 4'h0; addr = a;
        tick();
        en = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0; switch = 8'h00;
        repeat (3) tick();
        check("reset_rdata", rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);

        // Timer counts from 0 after release; read issued while it holds 5.
        resetn = 1'b1;
        repeat (5) tick();
        do_read(A_TIMER);
        check("timer_cycle5", rdata, 32'd5);
        tick();
        check("idle_holds", rdata, 32'd5);

        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        check("write_holds", rdata, 32'd5);
        do_read(32'h0000_0010);
        check("ram_word", rdata, 32'hDEAD_BEEF);

        do_write(32'h0000_0020, 32'h1122_3344, 4'hF);
        do_write(32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
        do_read(32'h0000_0020);
        check("byte_lanes", rdata, 32'h11BB_33DD);

        do_write(32'h0000_0000, 32'h0000_0005, 4'hF);
        do_read(32'h0000_1000);
        check("alias", rdata, 32'h0000_0005);

        do_write(A_LED, 32'h1234_ABCD, 4'hF);
        check("led_out", {16'h0, led}, 32'h0000_ABCD);
        do_read(A_LED);
        check("led_read", rdata, 32'h0000_ABCD);

        do_read(A_UNMAP);
        check("unmapped", rdata, 32'h0);

        do_write(A_SCRATCH, 32'hA5A5_5A5A, 4'hF);
        do_read(A_SCRATCH);
        check("scratch", rdata, 32'hA5A5_5A5A);

        switch = 8'h3C;
        repeat (3) tick();
        do_write(A_SWITCH, 32'hFFFF_FFFF, 4'hF);
        do_read(A_SWITCH);
        check("switch", rdata, 32'h0000_003C);

        do_read(32'h0000_0010);
        check("ram_after_mmio", rdata, 32'hDEAD_BEEF);

        // Timer write lands next cycle, then reads straddle the wrap.
        do_write(A_TIMER, 32'hFFFF_FFFE, 4'hF);
        en = 1'b1; wen = 4'h0; addr = A_TIMER;
        tick();
        check("timer_w0", rdata, 32'hFFFF_FFFE);
        tick();
        check("timer_w1", rdata, 32'hFFFF_FFFF);
        tick();
        check("timer_w2", rdata, 32'h0000_0000);
        en = 1'b0;

        // Writes coinciding with reset are dropped.
        resetn = 1'b0;
        do_write(A_SCRATCH, 32'h0000_0077, 4'hF);
        check("rst_rdata", rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        do_write(32'h0000_0010, 32'h0BAD_F00D, 4'hF);
        check("rst_rdata2", rdata, 32'h0);
        resetn = 1'b1;
        tick();
        do_read(A_SCRATCH);
        check("rst_scratch", rdata, 32'h0);
        do_read(32'h0000_0010);
        check("rst_ram_blocked", rdata, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
